zx_line_fetch: RTL

- Upstream neighbour of the VGA video controller. It fills a double-buffered scanline buffer of 4-bit colour indices, which the controller reads by pixel address and passes through its palette.
- On each new-line request it swaps banks, then fetches 32 bitmap and 32 attribute bytes of the next Spectrum line from screen RAM over a request/ack port.
- It expands those bytes to ink/paper/bright/flash indices and pads the line with border colour.

---
 rtl/zx_video_pkg.sv | 20 ++
 rtl/zx_line_fetch_if.sv | 12 +
 rtl/zx_line_ram.sv | 34 +++
 rtl/zx_line_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/zx_video_pkg.sv
// Shared constants and types for the Spectrum-style video path: line geometry, screen-RAM
// layout, fetch FSM states and the 4-bit colour index.
package zx_video_pkg;

  localparam int unsigned LINE_W    = 312;
  localparam int unsigned SCR_LINES = 192;
  localparam logic [12:0] ATTR_BASE = 13'h1800;

  typedef logic [3:0] colour_t;

  typedef enum logic [2:0] {
    StIdle,
    StLBord,
    StBmReq,
    StAtReq,
    StExpand,
    StRBord
  } fetch_state_e;

endpackage

// File: rtl/zx_line_fetch_if.sv
// Screen-RAM request/ack port: the fetcher holds mreq/maddr until mack, data valid with mack.
interface zx_line_fetch_if;

  logic        mreq;
  logic [12:0] maddr;
  logic [7:0]  mdata;
  logic        mack;

  modport master (output mreq, output maddr, input mdata, input mack);
  modport slave  (input mreq, input maddr, output mdata, output mack);

endinterface

// File: rtl/zx_line_ram.sv
// Two-bank scanline buffer, 2x512 colour indices: one synchronous write port and one
// registered read port on the same clock.
module zx_line_ram
  import zx_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [9:0] waddr,
  input  colour_t    wdata,
  input  logic [9:0] raddr,
  output colour_t    rdata
);

  colour_t mem [1024];
  colour_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/zx_line_fetch.sv
// Scanline fetcher: each new-line strike swaps banks, then fills the hidden bank with one
// Spectrum line (left border, 32 bitmap/attribute pairs expanded to indices, right border).
module zx_line_fetch
  import zx_video_pkg::*;
#(
  parameter int unsigned HBORDER    = 28,
  parameter int unsigned VBORDER    = 24,
  parameter int unsigned FLASH_BITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hnl,
  input  logic [9:0]      vcnext,
  input  logic            vblk,
  input  logic [2:0]      border,
  input  logic [8:0]      va,
  output colour_t         d,
  zx_line_fetch_if.master mem,
  output logic            ovr
);

  fetch_state_e          state_q, state_d;
  logic                  rbank_q, rbank_d;
  logic [8:0]            line_q, line_d;
  logic [2:0]            border_q, border_d;
  logic [8:0]            wptr_q, wptr_d;
  logic [4:0]            x_q, x_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            bmp_q, bmp_d;
  logic [7:0]            attr_q, attr_d;
  logic [FLASH_BITS-1:0] flash_q, flash_d;
  logic                  vblk_q, vblk_d;
  logic                  ovr_q, ovr_d;
  logic                  mreq_q, mreq_d;
  logic [12:0]           maddr_q, maddr_d;

  logic       we;
  colour_t    wdata;
  logic [7:0] y;
  logic       is_border;
  logic       last_entry;
  logic       pix_bit;
  colour_t    pix_idx;
  logic       unused_vcnext_lsb;

  assign unused_vcnext_lsb = vcnext[0];

  assign y          = 8'(line_q - 9'(VBORDER));
  assign is_border  = (line_q < 9'(VBORDER)) || (line_q >= 9'(VBORDER + SCR_LINES));
  assign last_entry = (wptr_q == 9'(LINE_W - 1));
  // Flashing cells swap ink and paper while the frame counter MSB is set.
  assign pix_bit    = bmp_q[7] ^ (attr_q[7] & flash_q[FLASH_BITS-1]);
  assign pix_idx    = pix_bit ? {attr_q[6], attr_q[2:0]} : {attr_q[6], attr_q[5:3]};

  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    line_d   = line_q;
    border_d = border_q;
    wptr_d   = wptr_q;
    x_d      = x_q;
    bit_d    = bit_q;
    bmp_d    = bmp_q;
    attr_d   = attr_q;
    mreq_d   = mreq_q;
    maddr_d  = maddr_q;
    ovr_d    = 1'b0;
    vblk_d   = vblk;
    flash_d  = flash_q;
    we       = 1'b0;
    wdata    = {1'b0, border_q};

    if (vblk && !vblk_q) begin
      flash_d = flash_q + FLASH_BITS'(1);
    end

    if (hnl) begin
      // A strike always wins: any outstanding request and same-cycle ack are dropped.
      ovr_d    = (state_q != StIdle);
      rbank_d  = ~rbank_q;
      line_d   = vcnext[9:1];
      border_d = border;
      wptr_d   = '0;
      x_d      = '0;
      bit_d    = '0;
      mreq_d   = 1'b0;
      state_d  = StLBord;
    end else begin
      case (state_q)
        StIdle: ;
        StLBord: begin
          we     = 1'b1;
          wptr_d = wptr_q + 9'd1;
          if (is_border) begin
            if (last_entry) state_d = StIdle;
          end else if (wptr_q == 9'(HBORDER - 1)) begin
            state_d = StBmReq;
          end
        end
        StBmReq: begin
          if (!mreq_q) begin
            mreq_d  = 1'b1;
            maddr_d = {y[7:6], y[2:0], y[5:3], x_q};
          end else if (mem.mack) begin
            bmp_d   = mem.mdata;
            mreq_d  = 1'b0;
            state_d = StAtReq;
          end
        end
        StAtReq: begin
          if (!mreq_q) begin
            mreq_d  = 1'b1;
            maddr_d = ATTR_BASE + {3'b000, y[7:3], x_q};
          end else if (mem.mack) begin
            attr_d  = mem.mdata;
            mreq_d  = 1'b0;
            state_d = StExpand;
          end
        end
        StExpand: begin
          we     = 1'b1;
          wdata  = pix_idx;
          wptr_d = wptr_q + 9'd1;
          bmp_d  = {bmp_q[6:0], 1'b0};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            x_d     = x_q + 5'd1;
            state_d = (x_q == 5'd31) ? StRBord : StBmReq;
          end
        end
        StRBord: begin
          we     = 1'b1;
          wptr_d = wptr_q + 9'd1;
          if (last_entry) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rbank_q  <= 1'b0;
      line_q   <= '0;
      border_q <= '0;
      wptr_q   <= '0;
      x_q      <= '0;
      bit_q    <= '0;
      bmp_q    <= '0;
      attr_q   <= '0;
      flash_q  <= '0;
      vblk_q   <= 1'b0;
      ovr_q    <= 1'b0;
      mreq_q   <= 1'b0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rbank_q  <= rbank_d;
      line_q   <= line_d;
      border_q <= border_d;
      wptr_q   <= wptr_d;
      x_q      <= x_d;
      bit_q    <= bit_d;
      bmp_q    <= bmp_d;
      attr_q   <= attr_d;
      flash_q  <= flash_d;
      vblk_q   <= vblk_d;
      ovr_q    <= ovr_d;
      mreq_q   <= mreq_d;
      maddr_q  <= maddr_d;
    end
  end

  zx_line_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr ({~rbank_q, wptr_q}),
    .wdata (wdata),
    .raddr ({rbank_q, va}),
    .rdata (d)
  );

  assign mem.mreq  = mreq_q;
  assign mem.maddr = maddr_q;
  assign ovr       = ovr_q;

endmodule
